stream_arbiter_qos_rr: RTL

//  Packet-level N:1 AXI-Stream-style arbiter: selects highest-QoS valid input, round-robin among equal QoS,

---
 rtl/stream_arb_pkg.sv | 48 ++++
 rtl/stream_skid_buf.sv | 68 ++++++
 rtl/stream_arbiter_qos_rr.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and the priority/round-robin pick helper for the stream arbiter.
// Contents:
//   arb_state_e : packet-level arbitration state (IDLE, BUSY)
//   rr_qos_t    : QoS vector, zero-extended to the helper's fixed maximum size
//   rr_pick()   : index of the highest-QoS valid stream, ties resolved to the
//                 first index at/after the round-robin pointer (with wrap)
package stream_arb_pkg;

  localparam int unsigned RR_MAX_STREAMS = 16;
  localparam int unsigned RR_MAX_QOS_W   = 8;
  localparam int unsigned RR_IDX_W       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef logic [RR_MAX_STREAMS-1:0][RR_MAX_QOS_W-1:0] rr_qos_t;

  // Walk the streams starting at ptr; a strictly greater QoS replaces the
  // current best, so equal QoS keeps the one closest after the pointer.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_STREAMS-1:0] valid,
    input rr_qos_t                   qos,
    input logic [RR_IDX_W-1:0]       ptr,
    input logic [RR_IDX_W:0]         count
  );
    logic [RR_IDX_W-1:0]   best_idx;
    logic [RR_MAX_QOS_W-1:0] best_qos;
    logic                  found;
    logic [RR_IDX_W:0]     idx;
    best_idx = '0;
    best_qos = '0;
    found    = 1'b0;
    for (int unsigned off = 0; off < RR_MAX_STREAMS; off++) begin
      idx = {1'b0, ptr} + (RR_IDX_W+1)'(off);
      if (idx >= count) idx = idx - count;
      if (((RR_IDX_W+1)'(off) < count) && valid[idx[RR_IDX_W-1:0]] &&
          (!found || (qos[idx[RR_IDX_W-1:0]] > best_qos))) begin
        found    = 1'b1;
        best_idx = idx[RR_IDX_W-1:0];
        best_qos = qos[idx[RR_IDX_W-1:0]];
      end
    end
    return best_idx;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready register slice. Output is fully registered; the input
// ready depends only on internal state, so it breaks the ready timing path.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data_i/valid/ready  : upstream beat interface
//   out_data_o/valid/ready : downstream beat interface (valid = slice non-empty)
module stream_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             push;
  logic             load_out;

  assign in_ready_o  = ~skid_valid_q;
  assign push        = in_valid_i & in_ready_o;
  assign load_out    = ~out_valid_q | out_ready_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  // Output register refills from the skid entry first to keep beat order.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (load_out) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data_i;
      end
    end else if (push) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/stream_arbiter_qos_rr.sv
// Packet-level N:1 stream arbiter: highest effective QoS wins, round-robin
// among equal QoS, grant held until the last beat is accepted. Output goes
// through a 2-entry skid slice; m_id_o tags the source stream.
// Optional build macro STREAM_ARB_AGING_EN: per-stream wait counters promote a
// starved stream to all-ones QoS after AGE_LIMIT cycles.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   s_data_i/s_qos_i (unpacked x N)   : per-stream payload and QoS
//   s_last_i/s_valid_i/s_ready_o      : per-stream handshake (ready one-hot)
//   m_data_o/m_qos_o/m_id_o/m_last_o  : output beat (qos is raw packet QoS)
//   m_valid_o/m_ready_i               : output handshake
module stream_arbiter_qos_rr
  import stream_arb_pkg::*;
#(
  parameter int unsigned STREAM_COUNT = 4,
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_QOS__WIDTH = 4,
  parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int unsigned AGE_WIDTH    = 4,
  parameter int unsigned AGE_LIMIT    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  if (STREAM_COUNT < 2 || STREAM_COUNT > RR_MAX_STREAMS || T_QOS__WIDTH > RR_MAX_QOS_W ||
      AGE_LIMIT >= (1 << AGE_WIDTH)) begin : g_bad_cfg
    $error("stream_arbiter_qos_rr: unsupported parameter set");
  end

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_QOS__WIDTH-1:0] qos;
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  arb_state_e                              state_q, state_d;
  logic [T_ID___WIDTH-1:0]                 lock_q, lock_d;
  logic [T_ID___WIDTH-1:0]                 rr_q, rr_d;
  logic [T_QOS__WIDTH-1:0]                 qos_q, qos_d;
  logic [T_ID___WIDTH-1:0]                 winner;
  logic [T_ID___WIDTH-1:0]                 grant_id;
  logic                                    grant_vld;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] eff_qos;
  logic [RR_MAX_STREAMS-1:0]               pick_valid;
  rr_qos_t                                 pick_qos;
  logic                                    skid_in_valid;
  logic                                    skid_in_ready;
  logic                                    accept;
  logic                                    first_beat;
  beat_t                                   in_beat;
  beat_t                                   out_beat;

`ifdef STREAM_ARB_AGING_EN
  logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0] age_q, age_d;

  // Starved streams compete at all-ones QoS; ties still go round-robin.
  always_comb begin
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      eff_qos[i] = (age_q[i] >= AGE_WIDTH'(AGE_LIMIT)) ? '1 : s_qos_i[i];
    end
  end

  // Count cycles spent valid but not accepted; reset on win or valid low.
  always_comb begin
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      age_d[i] = age_q[i];
      if (!s_valid_i[i] || (first_beat && (grant_id == T_ID___WIDTH'(i)))) begin
        age_d[i] = '0;
      end else if (!s_ready_o[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + AGE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      eff_qos[i] = s_qos_i[i];
    end
  end
`endif

  // Widen request vectors to the helper's fixed size.
  always_comb begin
    pick_valid = '0;
    pick_qos   = '0;
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      pick_valid[i] = s_valid_i[i];
      pick_qos[i]   = RR_MAX_QOS_W'(eff_qos[i]);
    end
  end

  assign winner = T_ID___WIDTH'(rr_pick(pick_valid, pick_qos, RR_IDX_W'(rr_q),
                                        (RR_IDX_W+1)'(STREAM_COUNT)));

  // Grant selection: free arbitration in IDLE, locked stream in BUSY.
  always_comb begin
    grant_id  = lock_q;
    grant_vld = 1'b1;
    if (state_q == IDLE) begin
      grant_id  = winner;
      grant_vld = |s_valid_i;
    end
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      s_ready_o[i] = grant_vld & skid_in_ready & (grant_id == T_ID___WIDTH'(i));
    end
    skid_in_valid = grant_vld & s_valid_i[grant_id];
    in_beat.data  = s_data_i[grant_id];
    in_beat.qos   = (state_q == IDLE) ? s_qos_i[grant_id] : qos_q;
    in_beat.id    = grant_id;
    in_beat.last  = s_last_i[grant_id];
  end

  assign accept     = skid_in_valid & skid_in_ready;
  assign first_beat = accept & (state_q == IDLE);

  // Next-state: lock on a multi-beat first beat, release on locked last beat.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    qos_d   = qos_q;
    case (state_q)
      IDLE: begin
        if (first_beat) begin
          rr_d  = (winner == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : winner + T_ID___WIDTH'(1);
          qos_d = s_qos_i[winner];
          if (!s_last_i[winner]) begin
            state_d = BUSY;
            lock_d  = winner;
          end
        end
      end
      BUSY: begin
        if (accept && s_last_i[lock_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      qos_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      qos_q   <= qos_d;
    end
  end

  stream_skid_buf #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_beat),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_in_ready),
    .out_data_o  (out_beat),
    .out_valid_o (m_valid_o),
    .out_ready_i (m_ready_i)
  );

  assign m_data_o = out_beat.data;
  assign m_qos_o  = out_beat.qos;
  assign m_id_o   = out_beat.id;
  assign m_last_o = out_beat.last;

endmodule
